// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory access sequencer (mem_access_ctrl).
package mem_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [2:0] bytes_for_dt(input logic [1:0] dt);
        case (dt)
            DT_BYTE: return 3'd1;
            DT_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Big-endian lane select: index 0 is the most significant byte of the n-byte value.
    function automatic logic [7:0] be_byte(input logic [31:0] data,
                                           input logic [2:0]  n,
                                           input logic [1:0]  idx);
        logic [1:0] pos;
        pos = 2'(n - 3'd1) - idx;
        return 8'(data >> {pos, 3'b000});
    endfunction

    function automatic logic is_misaligned(input logic [1:0] dt, input logic [1:0] lowAddr);
        case (dt)
            DT_BYTE: return 1'b0;
            DT_HALF: return lowAddr[0];
            default: return lowAddr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_slot_ctr.sv
// Tracks the wait cycle within a byte slot and the byte index of the current transfer.
module mem_byte_slot_ctr
    import mem_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_start,
    input  logic       i_run,
    input  logic [2:0] i_numBytes,
    output logic [1:0] o_byteIdx,
    output logic       o_lastCycle,
    output logic       o_lastByte
);

    logic [2:0] r_wait;
    logic [1:0] r_idx;

    always_ff @(posedge i_clk) begin
        if (i_clr || i_start) begin
            r_wait <= '0;
            r_idx  <= '0;
        end else if (i_run) begin
            if (o_lastCycle) begin
                r_wait <= '0;
                r_idx  <= r_idx + 2'd1;
            end else begin
                r_wait <= r_wait + 3'd1;
            end
        end
    end

    assign o_byteIdx   = r_idx;
    assign o_lastCycle = (r_wait == 3'(RAM_WAIT));
    assign o_lastByte  = (r_idx == 2'(i_numBytes - 3'd1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Splits byte/halfword/word MAR/MDR requests into big-endian single-byte RAM cycles.
// Define MISALIGN_CHECK_EN to fault misaligned halfword/word requests without any RAM access.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RAM_WAIT = 1
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_mov,
    input  logic              i_r_w,
    input  logic [1:0]        i_dt,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_moc,
    output logic              o_fault,
    output logic              o_ram_en,
    output logic              o_ram_rw,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_wdata,
    input  logic [7:0]        i_ram_rdata
);

    state_t            r_state;
    logic              r_rw;
    logic [2:0]        r_nBytes;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [23:0]       r_asm;
    logic              r_launch;
    logic [31:0]       r_rdata;
    logic              r_moc;
    logic              r_ramEn;
    logic              r_ramRw;
    logic [ADDR_W-1:0] r_ramAddr;
    logic [7:0]        r_ramWdata;
`ifdef MISALIGN_CHECK_EN
    logic              r_misalign;
    logic              r_fault;
`endif

    logic [1:0] w_byteIdx;
    logic       w_lastCycle;
    logic       w_lastByte;
    logic       w_start;
    logic       w_run;

    assign w_start = (r_state == ST_ACCESS) && r_launch;
    assign w_run   = (r_state == ST_ACCESS) && !r_launch;

    mem_byte_slot_ctr #(.RAM_WAIT(RAM_WAIT)) u_slotCtr (
        .i_clk      (i_clk),
        .i_clr      (i_clr),
        .i_start    (w_start),
        .i_run      (w_run),
        .i_numBytes (r_nBytes),
        .o_byteIdx  (w_byteIdx),
        .o_lastCycle(w_lastCycle),
        .o_lastByte (w_lastByte)
    );

    // The first ACCESS cycle only launches byte 0, which gives the fixed k+1 setup latency.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state    <= ST_IDLE;
            r_rw       <= 1'b0;
            r_nBytes   <= 3'd1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_asm      <= '0;
            r_launch   <= 1'b0;
            r_rdata    <= '0;
            r_moc      <= 1'b0;
            r_ramEn    <= 1'b0;
            r_ramRw    <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
`ifdef MISALIGN_CHECK_EN
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_mov) begin
                        r_rw     <= i_r_w;
                        r_nBytes <= bytes_for_dt(i_dt);
                        r_addr   <= i_addr;
                        r_wdata  <= i_wdata;
                        r_asm    <= '0;
                        r_launch <= 1'b1;
`ifdef MISALIGN_CHECK_EN
                        r_misalign <= is_misaligned(i_dt, i_addr[1:0]);
`endif
                        r_state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_launch) begin
                        r_launch <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                        if (r_misalign) begin
                            r_state <= ST_DONE;
                            r_moc   <= 1'b1;
                            r_fault <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            r_ramEn    <= 1'b1;
                            r_ramRw    <= r_rw;
                            r_ramAddr  <= r_addr;
                            r_ramWdata <= be_byte(r_wdata, r_nBytes, 2'd0);
                        end
                    end else if (w_lastCycle) begin
                        r_asm <= {r_asm[15:0], i_ram_rdata};
                        if (w_lastByte) begin
                            r_ramEn <= 1'b0;
                            r_state <= ST_DONE;
                            r_moc   <= 1'b1;
                            if (r_rw) begin
                                r_rdata <= {r_asm, i_ram_rdata};
                            end
                        end else begin
                            r_ramAddr  <= r_addr + ADDR_W'(w_byteIdx) + ADDR_W'(1);
                            r_ramWdata <= be_byte(r_wdata, r_nBytes, w_byteIdx + 2'd1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!i_mov) begin
                        r_state <= ST_IDLE;
                        r_moc   <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                        r_fault <= 1'b0;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rdata     = r_rdata;
    assign o_moc       = r_moc;
    assign o_ram_en    = r_ramEn;
    assign o_ram_rw    = r_ramRw;
    assign o_ram_addr  = r_ramAddr;
    assign o_ram_wdata = r_ramWdata;
`ifdef MISALIGN_CHECK_EN
    assign o_fault     = r_fault;
`else
    assign o_fault     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table, strobe/completion scoreboards, reset abort.
module tb_mem_access_ctrl;

    localparam int RAM_WAIT = 1;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        mov = 1'b0;
    logic        rw = 1'b0;
    logic [1:0]  dt = 2'b00;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        moc;
    logic        fault;
    logic        ramEn;
    logic        ramRw;
    logic [7:0]  ramAddr;
    logic [7:0]  ramWdata;
    logic [7:0]  ramRdata;

    mem_access_ctrl #(.ADDR_W(8), .RAM_WAIT(RAM_WAIT)) dut (
        .i_clk      (clk),
        .i_clr      (clr),
        .i_mov      (mov),
        .i_r_w      (rw),
        .i_dt       (dt),
        .i_addr     (addr),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_moc      (moc),
        .o_fault    (fault),
        .o_ram_en   (ramEn),
        .o_ram_rw   (ramRw),
        .o_ram_addr (ramAddr),
        .o_ram_wdata(ramWdata),
        .i_ram_rdata(ramRdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  dt;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          hold;
        logic        dropEarly;
        logic [31:0] expRdata;
        logic        expFault;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [31:0] expRdata;
        logic        expFault;
        int          expLat;
        int          startEdge;
    } tx_t;

    typedef struct {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] wbyte;
    } strobe_t;

    tx_t     txQ[$];
    strobe_t strobeQ[$];
    vec_t    vecs[12];

    int   nCompared = 0;
    int   nMismatch = 0;
    int   cycle = 0;
    logic mocPrev = 1'b0;
    logic [7:0] mem [0:255];
    bit   memInit = 1'b0;

    function automatic logic [7:0] initVal(input int a);
        case (a)
            'h10: return 8'hDE;  'h11: return 8'hAD;  'h12: return 8'hBE;  'h13: return 8'hEF;
            'hFE: return 8'h11;  'hFF: return 8'h22;  'h00: return 8'h33;  'h01: return 8'h44;
            'h22: return 8'h77;  'h30: return 8'h80;
            'h50: return 8'hA0;  'h51: return 8'hA1;  'h52: return 8'hA2;  'h53: return 8'hA3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] expByte(input logic [31:0] w, input int n, input int i);
        if (n == 4) begin
            case (i)
                0: return w[31:24];
                1: return w[23:16];
                2: return w[15:8];
                default: return w[7:0];
            endcase
        end else if (n == 2) begin
            return (i == 0) ? w[15:8] : w[7:0];
        end
        return w[7:0];
    endfunction

    function automatic int bytesOf(input logic [1:0] d);
        return (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
    endfunction

    // Byte-wide RAM model: combinational read, write on the clock edge.
    assign ramRdata = (ramEn && ramRw) ? mem[ramAddr] : 8'h00;

    always @(posedge clk) begin
        if (!memInit) begin
            for (int a = 0; a < 256; a++) mem[a] = initVal(a);
            memInit = 1'b1;
        end else if (ramEn && !ramRw) begin
            mem[ramAddr] = ramWdata;
        end
    end

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pops expected strobes and completions as the DUT produces them.
    always @(negedge clk) begin
        if (ramEn) begin
            if (strobeQ.size() == 0) begin
                checkOutput("unexpected_ram_en", 32'(ramEn), 32'h0);
            end else begin
                strobe_t s;
                s = strobeQ.pop_front();
                checkOutput("ram_addr", 32'(ramAddr), 32'(s.addr));
                checkOutput("ram_rw", 32'(ramRw), 32'(s.rw));
                if (!s.rw) checkOutput("ram_wdata", 32'(ramWdata), 32'(s.wbyte));
            end
        end
        if (moc && !mocPrev) begin
            if (txQ.size() == 0) begin
                checkOutput("unexpected_moc", 32'(moc), 32'h0);
            end else begin
                tx_t t;
                t = txQ.pop_front();
                checkOutput("moc_latency", 32'(cycle - t.startEdge), 32'(t.expLat));
                checkOutput("rdata", rdata, t.expRdata);
                checkOutput("fault", 32'(fault), 32'(t.expFault));
            end
        end
        mocPrev = moc;
    end

    task automatic pushStrobes(input vec_t v, input int nBytesToPush);
        for (int i = 0; i < nBytesToPush; i++) begin
            for (int w = 0; w <= RAM_WAIT; w++) begin
                strobe_t s;
                s.addr  = v.addr + 8'(i);
                s.rw    = v.rw;
                s.wbyte = expByte(v.wdata, bytesOf(v.dt), i);
                strobeQ.push_back(s);
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        tx_t t;
        int  waited;
        @(negedge clk);
        mov = 1'b1; rw = v.rw; dt = v.dt; addr = v.addr; wdata = v.wdata;
        t.expRdata = v.expRdata; t.expFault = v.expFault; t.expLat = v.expLat;
        t.startEdge = cycle + 1;
        txQ.push_back(t);
        if (!v.expFault) pushStrobes(v, bytesOf(v.dt));
        @(negedge clk);
        rw = ~rw; dt = ~dt; addr = ~addr; wdata = ~wdata;
        if (v.dropEarly) mov = 1'b0;
        waited = 0;
        while (!moc && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!moc) begin
            checkOutput("moc_timeout", 32'(moc), 32'h1);
            txQ.delete();
            strobeQ.delete();
        end
        checkOutput("strobes_left", 32'(strobeQ.size()), 32'h0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            checkOutput("moc_held", 32'(moc), 32'h1);
        end
        mov = 1'b0;
        @(negedge clk);
        checkOutput("moc_drop", 32'(moc), 32'h0);
        checkOutput("fault_drop", 32'(fault), 32'h0);
        checkOutput("ram_en_idle", 32'(ramEn), 32'h0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_moc"}, 32'(moc), 32'h0);
        checkOutput({tag, "_fault"}, 32'(fault), 32'h0);
        checkOutput({tag, "_ram_en"}, 32'(ramEn), 32'h0);
        checkOutput({tag, "_ram_rw"}, 32'(ramRw), 32'h0);
        checkOutput({tag, "_ram_addr"}, 32'(ramAddr), 32'h0);
        checkOutput({tag, "_ram_wdata"}, 32'(ramWdata), 32'h0);
        checkOutput({tag, "_rdata"}, rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        //            rw    dt     addr   wdata          hold drop  expRdata       fault lat
        vecs[0]  = '{1'b1, 2'b10, 8'h10, 32'h0,         5, 1'b0, 32'hDEADBEEF, 1'b0, 9};
        vecs[1]  = '{1'b0, 2'b01, 8'h20, 32'h1234ABCD,  0, 1'b0, 32'hDEADBEEF, 1'b0, 5};
        vecs[2]  = '{1'b1, 2'b01, 8'h20, 32'h0,         0, 1'b0, 32'h0000ABCD, 1'b0, 5};
        vecs[3]  = '{1'b1, 2'b00, 8'h22, 32'h0,         0, 1'b1, 32'h00000077, 1'b0, 3};
        vecs[4]  = '{1'b1, 2'b00, 8'h30, 32'h0,         0, 1'b0, 32'h00000080, 1'b0, 3};
`ifdef MISALIGN_CHECK_EN
        vecs[5]  = '{1'b1, 2'b10, 8'hFE, 32'h0,         2, 1'b0, 32'h00000080, 1'b1, 1};
        vecs[6]  = '{1'b0, 2'b10, 8'h40, 32'hCAFEF00D,  0, 1'b0, 32'h00000080, 1'b0, 9};
`else
        vecs[5]  = '{1'b1, 2'b10, 8'hFE, 32'h0,         2, 1'b0, 32'h11223344, 1'b0, 9};
        vecs[6]  = '{1'b0, 2'b10, 8'h40, 32'hCAFEF00D,  0, 1'b0, 32'h11223344, 1'b0, 9};
`endif
        vecs[7]  = '{1'b1, 2'b10, 8'h40, 32'h0,         0, 1'b0, 32'hCAFEF00D, 1'b0, 9};
        vecs[8]  = '{1'b0, 2'b00, 8'h44, 32'hFFFFFF5A,  0, 1'b1, 32'hCAFEF00D, 1'b0, 3};
`ifdef MISALIGN_CHECK_EN
        vecs[9]  = '{1'b1, 2'b01, 8'h43, 32'h0,         0, 1'b0, 32'hCAFEF00D, 1'b1, 1};
`else
        vecs[9]  = '{1'b1, 2'b01, 8'h43, 32'h0,         0, 1'b0, 32'h00000D5A, 1'b0, 5};
`endif
        vecs[10] = '{1'b1, 2'b11, 8'h10, 32'h0,         0, 1'b0, 32'hDEADBEEF, 1'b0, 9};
        vecs[11] = '{1'b1, 2'b00, 8'h44, 32'h0,         0, 1'b0, 32'h0000005A, 1'b0, 3};

        clr = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        clr = 1'b0;

        for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

        // Abort a word write while its third byte would be launched.
        @(negedge clk);
        v = '{1'b0, 2'b10, 8'h50, 32'h11223344, 0, 1'b0, 32'h0, 1'b0, 9};
        mov = 1'b1; rw = v.rw; dt = v.dt; addr = v.addr; wdata = v.wdata;
        pushStrobes(v, 2);
        repeat (5) @(negedge clk);
        clr = 1'b1;
        mov = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        clr = 1'b0;
        checkOutput("abort_strobes_left", 32'(strobeQ.size()), 32'h0);
        checkOutput("abort_mem50", 32'(mem[8'h50]), 32'h11);
        checkOutput("abort_mem51", 32'(mem[8'h51]), 32'h22);
        checkOutput("abort_mem52", 32'(mem[8'h52]), 32'hA2);
        checkOutput("abort_mem53", 32'(mem[8'h53]), 32'hA3);
        strobeQ.delete();

        v = '{1'b1, 2'b10, 8'h50, 32'h0, 0, 1'b0, 32'h1122A2A3, 1'b0, 9};
        applyStimulus(v);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer between the CPU datapath's MAR/MDR and the byte-wide 256x8 RAM. It accepts one byte, halfword or word request per MOV/MOC handshake from the control unit. It splits the request into single-byte RAM cycles in big-endian order, assembles read data, and returns MOC when the whole transfer is done. This replaces the control unit's direct multi-byte access to RAM with a clocked, deterministic-latency stage.

Parameters:
ADDR_W, 8, RAM address width; all byte addresses wrap modulo 2**ADDR_W.
RAM_WAIT, 1, extra wait cycles per byte access (0..7); each byte occupies RAM_WAIT+1 cycles.

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, synchronous, active-high
mov  in  1  memory operation valid, from control unit
r_w  in  1  1 = read, 0 = write
dt  in  2  data type: 00 byte, 01 halfword, 10 word, 11 word (alias)
addr  in  ADDR_W  byte address (MAR)
wdata  in  32  write data (MDR)
rdata  out  32  read data, zero-extended
moc  out  1  memory operation complete
fault  out  1  misaligned-access flag (MISALIGN_CHECK_EN only, else tied 0)
ram_en  out  1  RAM byte strobe
ram_rw  out  1  RAM direction, 1 = read
ram_addr  out  ADDR_W  RAM byte address
ram_wdata  out  8  RAM write byte
ram_rdata  in  8  RAM read byte

Behaviour:
- Reset (clr high at a rising edge): state IDLE. moc, fault, ram_en, ram_rw, ram_addr, ram_wdata and rdata all 0. clr mid-transfer aborts immediately. Bytes already written stay in RAM; there is no rollback.
- States are IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: when mov=1 at edge k, capture r_w, dt, addr and wdata; set N = 1/2/4 for byte/halfword/word; byte index i=0; go to ACCESS.
- ACCESS: byte i is driven for RAM_WAIT+1 cycles. During that time ram_en=1, ram_rw=captured r_w, and ram_addr=(addr+i) mod 2**ADDR_W.
- Write byte order is big-endian. Word: i0=wdata[31:24] through i3=wdata[7:0]. Halfword: i0=wdata[15:8], i1=wdata[7:0]. Byte: wdata[7:0].
- Reads sample ram_rdata in the last cycle of each byte slot and shift it into an assembly register (MSB first).
- After byte N-1, ram_en drops to 0 and the state goes to DONE.
- Latency: DONE and moc=1 appear in cycle k+1+N*(RAM_WAIT+1). With RAM_WAIT=1: byte k+3, halfword k+5, word k+9.
- DONE on a read: rdata is loaded with the zero-extended assembly value in the same cycle moc rises. rdata holds until the next completed read; writes never change rdata.
- DONE handshake: moc stays 1 while mov=1. On the first edge with mov=0, go to IDLE with moc=0. A new request therefore needs mov to drop for at least one cycle.
- If mov drops during ACCESS, the transfer still completes and moc pulses for exactly one cycle.
- Inputs changing during ACCESS are ignored because they were captured at the start.

Optional Feature:
MISALIGN_CHECK_EN defined:
- A halfword with addr[0]=1, or a word with addr[1:0]!=0, skips ACCESS entirely: no ram_en, and IDLE goes straight to DONE at k+1.
- In that case fault=1 for the DONE duration and rdata is unchanged.
- fault clears when the state returns to IDLE.

MISALIGN_CHECK_EN undefined:
- Misaligned accesses proceed byte by byte with address wrap.
- fault is constant 0.

Decomposition:
- Shared package (mem_pkg): DT_BYTE/DT_HALF/DT_WORD constants, state encoding, and a function bytes_for_dt(dt).
- One sub-module, mem_byte_slot_ctr: counts RAM_WAIT+1 cycles per byte and the byte index, and flags the last cycle and last byte.

Test Plan:
- Word read: RAM[0x10..0x13]=DE,AD,BE,EF, RAM_WAIT=1, mov=1 r_w=1 dt=10 addr=0x10 at edge k -> ram_addr 10,11,12,13, each for 2 cycles; moc=1 at k+9; rdata=0xDEADBEEF.
- Halfword write: wdata=0x1234ABCD, dt=01, addr=0x20 -> RAM[0x20]=AB, RAM[0x21]=CD, RAM[0x22] untouched; moc at k+5; rdata unchanged.
- Byte read and wrap: addr=0xFE, word read with check disabled -> addresses FE,FF,00,01; byte read of 0x80 -> rdata=0x00000080 (zero-extended).
- Handshake: hold mov=1 for 5 cycles after moc -> moc stays 1. Drop mov -> moc=0 next edge. Raise mov again -> a new transfer starts.
- Reset mid-op: assert clr at the 3rd byte of a word write -> next cycle all outputs are 0 and state is IDLE; RAM bytes 0 and 1 are written and bytes 2 and 3 are not.
- MISALIGN_CHECK_EN: word read at addr=0x05 -> no ram_en; moc=1 and fault=1 at k+1; rdata unchanged.
